// File: rtl/seq_restoring_divider_16by8.sv
// Sequential restoring divider: 16-bit unsigned dividend / 8-bit unsigned divisor,
// one quotient bit per cycle, valid/ready handshakes on both sides.
module seq_restoring_divider_16by8 #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVISOR_W-1:0]  quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  err_div0,
    output logic                  err_ovf
);

    localparam int Q_W   = DIVISOR_W;
    localparam int CNT_W = $clog2(Q_W + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state, state_nxt;
    logic [DIVISOR_W-1:0]   rem_acc;
    logic [Q_W-1:0]         shf;
    logic [CNT_W-1:0]       cnt;
    logic [DIVISOR_W-1:0]   dvsr;
    logic                   pend_div0, pend_ovf;

    logic [DIVISOR_W-1:0]   dividend_hi;
    logic                   is_div0, is_ovf;
    logic [DIVISOR_W:0]     trial;
    logic                   trial_ge;
    logic [DIVISOR_W-1:0]   rem_step;
    logic [Q_W-1:0]         shf_step;
    logic                   last_step;

    assign dividend_hi = dividend[DIVIDEND_W-1:DIVISOR_W];
    assign is_div0     = (divisor == '0);
    assign is_ovf      = (dividend_hi >= divisor);

    // Trial compare is DIVISOR_W+1 bits wide; the difference always fits in
    // DIVISOR_W bits because it is strictly less than the divisor.
    assign trial     = {rem_acc, shf[Q_W-1]};
    assign trial_ge  = (trial >= {1'b0, dvsr});
    assign rem_step  = trial_ge ? (trial[DIVISOR_W-1:0] - dvsr) : trial[DIVISOR_W-1:0];
    assign shf_step  = {shf[Q_W-2:0], trial_ge};
    assign last_step = (cnt == CNT_W'(1));

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = BUSY;
            BUSY:    if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Error cases pass through BUSY for a single cycle so they report one edge
    // after accept; the low dividend byte waits in shf as the remainder.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_acc   <= '0;
            shf       <= '0;
            cnt       <= '0;
            dvsr      <= '0;
            pend_div0 <= 1'b0;
            pend_ovf  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            err_div0  <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvsr      <= divisor;
                        rem_acc   <= dividend_hi;
                        shf       <= dividend[DIVISOR_W-1:0];
                        pend_div0 <= is_div0;
                        pend_ovf  <= !is_div0 && is_ovf;
                        cnt       <= (is_div0 || is_ovf) ? CNT_W'(1) : CNT_W'(Q_W);
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (pend_div0 || pend_ovf) begin
                        quotient  <= '1;
                        remainder <= shf;
                        err_div0  <= pend_div0;
                        err_ovf   <= pend_ovf;
                    end else begin
                        rem_acc <= rem_step;
                        shf     <= shf_step;
                        if (last_step) begin
                            quotient  <= shf_step;
                            remainder <= rem_step;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        err_div0 <= 1'b0;
                        err_ovf  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider_16by8.sv
// Scoreboard bench for seq_restoring_divider_16by8: directed vectors push expected
// results; a negedge monitor pops and compares on each output handshake.
module tb_seq_restoring_divider_16by8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        err_div0;
    logic        err_ovf;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       d0;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    seq_restoring_divider_16by8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .err_div0  (err_div0),
        .err_ovf   (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: a result is consumed on the next rising edge when both are high.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_result", exp_q.size(), 1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_quotient",  quotient,  e.q);
                check("sb_remainder", remainder, e.r);
                check("sb_err_div0",  err_div0,  e.d0);
                check("sb_err_ovf",   err_ovf,   e.ovf);
            end
        end
    end

    // Issues one operation, pushes its expected result, and checks the number of
    // edges from the accept edge until out_valid is observed.
    task automatic issue(input logic [15:0] dd, input logic [7:0] dv,
                         input logic [7:0] q, input logic [7:0] r,
                         input logic d0, input logic ovf, input int lat, input string name);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_in_ready"}, in_ready, 1);
        dividend = dd;
        divisor  = dv;
        in_valid = 1'b1;
        exp_q.push_back('{q, r, d0, ovf});
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_latency"}, n, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient",  quotient,  0);
        check("rst_remainder", remainder, 0);
        check("rst_errs",      {err_div0, err_ovf}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(16'h6018, 8'h7B, 8'hC8, 8'h00, 1'b0, 1'b0, 8, "exact");
        issue(16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, 1'b0, 8, "rem");
        issue(16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 8, "maxq");
        issue(16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0, 1, "div0");
        issue(16'h1234, 8'h12, 8'hFF, 8'h34, 1'b0, 1'b1, 1, "ovf");
        issue(16'h11FF, 8'h12, 8'hFF, 8'h11, 1'b0, 1'b0, 8, "ovf_edge");
        issue(16'h0000, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, 8, "zero");
        issue(16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 8, "div1");
        issue(16'h0000, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1, "div0_zero");

        // Backpressure: result must hold and new operands must be ignored.
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(16'h6018, 8'h7B, 8'hC8, 8'h00, 1'b0, 1'b0, 8, "bp");
        dividend = 16'h1234;
        divisor  = 8'h00;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_quotient",  quotient,  8'hC8);
            check("bp_hold_remainder", remainder, 8'h00);
            check("bp_hold_errs",      {err_div0, err_ovf}, 0);
            check("bp_hold_out_valid", out_valid, 1);
            check("bp_hold_in_ready",  in_ready,  0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready",  in_ready,  1);
        issue(16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, 1'b0, 8, "bp_after");

        // Error flags must clear after an error result is consumed.
        issue(16'h1234, 8'h12, 8'hFF, 8'h34, 1'b0, 1'b1, 1, "ovf2");
        @(posedge clk); #1;
        check("ovf_clear_errs", {err_div0, err_ovf}, 0);

        // Reset during BUSY discards the operation.
        dividend = 16'h6018;
        divisor  = 8'h7B;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midbusy_busy", in_ready, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready",  in_ready,  1);
        check("midrst_quotient",  quotient,  0);
        check("midrst_remainder", remainder, 0);
        check("midrst_errs",      {err_div0, err_ovf}, 0);
        rst_n = 1'b1;
        issue(16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, 1'b0, 8, "post_rst");

        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
